// File: rtl/sobel_pkg.sv
// Shared widths, FSM encoding and arithmetic helper for the
// horizontal Sobel stream driver.
package sobel_pkg;

   localparam int PIX_W = 8;
   localparam int INT_W = 10;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic [INT_W-1:0] abs_diff(
      input logic [INT_W-1:0] a,
      input logic [INT_W-1:0] b
   );
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One row of pixels; combinational read of the old value at the
// same index that is written on the clock edge.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    idx_i,
   input  logic [PIX_W-1:0] wdata_i,
   output logic [PIX_W-1:0] rdata_o
);

   logic [PIX_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/sobel_x_stream_driver.sv
// Streaming |Gx| Sobel filter: raster pixels in, one registered
// result per interior pixel out, valid/ready on both sides.
module sobel_x_stream_driver
   import sobel_pkg::*;
#(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [INT_W-1:0] sobel_X_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   state_t           state_q;
   logic [INT_W-1:0] i1_q, i2_q, out_q;
   logic             valid_q, last_q;

   logic             accept, col_last, row_last;
   logic [PIX_W-1:0] l1_rd, l2_rd;
   logic [INT_W-1:0] i_cur;

   assign pix_ready   = rst || !valid_q || out_ready;
   assign accept      = pix_valid && pix_ready && !rst;
   assign col_last    = (col_q == COL_LAST);
   assign row_last    = (row_q == ROW_LAST);
   assign sobel_X_out = out_q;
   assign out_valid   = valid_q;
   assign out_last    = last_q;

   // L2 takes what L1 held at this column, so rows age by one per pass.
   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_l2 (
      .clk     (clk),
      .we_i    (accept),
      .idx_i   (col_q),
      .wdata_i (l1_rd),
      .rdata_o (l2_rd)
   );

   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_l1 (
      .clk     (clk),
      .we_i    (accept),
      .idx_i   (col_q),
      .wdata_i (pix_in),
      .rdata_o (l1_rd)
   );

   assign i_cur = INT_W'(l2_rd)
                + INT_W'({l1_rd, 1'b0})
                + INT_W'(pix_in);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         state_q <= FILL;
         i1_q    <= '0;
         i2_q    <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
         if (accept) begin
            i1_q <= i_cur;
            i2_q <= (col_q == '0) ? '0 : i1_q;
            unique case (state_q)
               FILL: begin
                  if (col_last && row_q == RW'(1)) begin
                     state_q <= RUN;
                  end
               end
               RUN: begin
                  if (col_q >= CW'(2)) begin
                     out_q   <= abs_diff(i_cur, i2_q);
                     valid_q <= 1'b1;
                     last_q  <= row_last && col_last;
                  end
                  if (col_last && row_last) begin
                     state_q <= FILL;
                  end
               end
            endcase
         end
      end
   end

endmodule
